// File: rtl/mips_enc_pkg.sv
// Mnemonic IDs, MIPS opcode/funct codes and the descriptor-to-word encoder.
// ENC_EXT_EN enables shifts, jr/jalr and byte/half memory ops.
package mips_enc_pkg;

  typedef enum logic [5:0] {
    ID_ADD, ID_ADDU, ID_SUB, ID_SUBU,
    ID_AND, ID_OR, ID_XOR, ID_NOR,
    ID_SLT, ID_SLTU,
    ID_SLL, ID_SRL, ID_SRA,
    ID_SLLV, ID_SRLV, ID_SRAV,
    ID_JR, ID_JALR,
    ID_ADDI, ID_SLTI, ID_ANDI, ID_ORI,
    ID_LUI, ID_BEQ, ID_BNE,
    ID_J, ID_JAL,
    ID_LW, ID_SW,
    ID_LB, ID_LH, ID_LBU, ID_LHU,
    ID_SB, ID_SH
  } mnem_e;

  typedef enum logic [1:0] {
    FMT_R, FMT_SHIFT, FMT_I, FMT_J
  } fmt_e;

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DONE
  } state_e;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_LH   = 6'b100001;
  localparam logic [5:0] OP_LBU  = 6'b100100;
  localparam logic [5:0] OP_LHU  = 6'b100101;
  localparam logic [5:0] OP_SB   = 6'b101000;
  localparam logic [5:0] OP_SH   = 6'b101001;

  function automatic enc_t encode(
    input logic [5:0]  id,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  sh,
    input logic [15:0] imm,
    input logic [25:0] tgt,
    input logic        ext
  );
    enc_t       e;
    fmt_e       fmt;
    logic [5:0] code;
    logic       known;
    logic       xt;
    logic [4:0] rs_m;
    logic [4:0] rt_m;
    logic [4:0] rd_m;
    fmt   = FMT_R;
    code  = '0;
    known = 1'b1;
    xt    = 1'b0;
    unique case (id)
      ID_ADD:  code = FN_ADD;
      ID_ADDU: code = FN_ADDU;
      ID_SUB:  code = FN_SUB;
      ID_SUBU: code = FN_SUBU;
      ID_AND:  code = FN_AND;
      ID_OR:   code = FN_OR;
      ID_XOR:  code = FN_XOR;
      ID_NOR:  code = FN_NOR;
      ID_SLT:  code = FN_SLT;
      ID_SLTU: code = FN_SLTU;
      ID_SLL:  begin fmt = FMT_SHIFT; code = FN_SLL; xt = 1'b1; end
      ID_SRL:  begin fmt = FMT_SHIFT; code = FN_SRL; xt = 1'b1; end
      ID_SRA:  begin fmt = FMT_SHIFT; code = FN_SRA; xt = 1'b1; end
      ID_SLLV: begin code = FN_SLLV; xt = 1'b1; end
      ID_SRLV: begin code = FN_SRLV; xt = 1'b1; end
      ID_SRAV: begin code = FN_SRAV; xt = 1'b1; end
      ID_JR:   begin code = FN_JR; xt = 1'b1; end
      ID_JALR: begin code = FN_JALR; xt = 1'b1; end
      ID_ADDI: begin fmt = FMT_I; code = OP_ADDI; end
      ID_SLTI: begin fmt = FMT_I; code = OP_SLTI; end
      ID_ANDI: begin fmt = FMT_I; code = OP_ANDI; end
      ID_ORI:  begin fmt = FMT_I; code = OP_ORI; end
      ID_LUI:  begin fmt = FMT_I; code = OP_LUI; end
      ID_BEQ:  begin fmt = FMT_I; code = OP_BEQ; end
      ID_BNE:  begin fmt = FMT_I; code = OP_BNE; end
      ID_J:    begin fmt = FMT_J; code = OP_J; end
      ID_JAL:  begin fmt = FMT_J; code = OP_JAL; end
      ID_LW:   begin fmt = FMT_I; code = OP_LW; end
      ID_SW:   begin fmt = FMT_I; code = OP_SW; end
      ID_LB:   begin fmt = FMT_I; code = OP_LB; xt = 1'b1; end
      ID_LH:   begin fmt = FMT_I; code = OP_LH; xt = 1'b1; end
      ID_LBU:  begin fmt = FMT_I; code = OP_LBU; xt = 1'b1; end
      ID_LHU:  begin fmt = FMT_I; code = OP_LHU; xt = 1'b1; end
      ID_SB:   begin fmt = FMT_I; code = OP_SB; xt = 1'b1; end
      ID_SH:   begin fmt = FMT_I; code = OP_SH; xt = 1'b1; end
      default: known = 1'b0;
    endcase
    rs_m = (id == ID_LUI) ? 5'd0 : rs;
    rt_m = (id == ID_JR || id == ID_JALR) ? 5'd0 : rt;
    rd_m = (id == ID_JR) ? 5'd0 : rd;
    e.legal = known & (~xt | ext);
    unique case (fmt)
      FMT_R:     e.word = {6'b0, rs, rt_m, rd_m, 5'b0, code};
      FMT_SHIFT: e.word = {6'b0, 5'b0, rt, rd, sh, code};
      FMT_I:     e.word = {code, rs_m, rt, imm};
      FMT_J:     e.word = {code, tgt};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/mips_instr_encoder_fifo.sv
// Synchronous FIFO buffering encoded words ahead of the IMEM port.
// Pointers carry one extra wrap bit to tell full from empty.
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wp_q;
  logic [AW:0]  rp_q;
  logic         do_push;
  logic         do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (wp_q == rp_q);
  assign full    = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign rdata   = mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q <= '0;
      rp_q <= '0;
    end else if (clr) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + (AW+1)'(1);
      if (do_pop)  rp_q <= rp_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Streaming MIPS encoder / IMEM loader; ENC_EXT_EN adds shifts,
// jr/jalr and byte/half loads and stores.
import mips_enc_pkg::*;

module mips_instr_encoder #(
  parameter int ADDR_W     = 10,
  parameter int BASE       = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_id,
  input  logic              in_last,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_illegal,
  output logic              err_overflow
);
`ifdef ENC_EXT_EN
  localparam logic EXT_EN = 1'b1;
`else
  localparam logic EXT_EN = 1'b0;
`endif
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  state_e            state_q;
  logic [ADDR_W:0]   wptr_q;
  logic [ADDR_W:0]   cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              ill_q;
  logic              ovf_q;

  enc_t        enc;
  logic        accept;
  logic        push;
  logic        pop;
  logic        clr;
  logic        full;
  logic        empty;
  logic [31:0] head;

  assign enc = encode(in_id, in_rs, in_rt, in_rd, in_shamt,
                      in_imm, in_target, EXT_EN);

  assign in_ready = (state_q == S_RUN) & ~full;
  assign accept   = in_valid & in_ready;
  assign push     = accept & enc.legal;
  assign pop      = ~empty;
  assign clr      = start &
                    (state_q == S_IDLE || state_q == S_DONE);

  enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (clr),
    .push  (push),
    .wdata (enc.word),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // wptr carries an extra bit: set means the IMEM window is exhausted
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      wptr_q  <= (ADDR_W+1)'(BASE);
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ill_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (pop) begin
        if (wptr_q[ADDR_W]) begin
          ovf_q <= 1'b1;
        end else begin
          we_q    <= 1'b1;
          addr_q  <= wptr_q[ADDR_W-1:0];
          wdata_q <= head;
          wptr_q  <= wptr_q + ONE;
          cnt_q   <= cnt_q + ONE;
        end
      end
      if (accept && !enc.legal) ill_q <= 1'b1;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_RUN;
            wptr_q  <= (ADDR_W+1)'(BASE);
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            ovf_q   <= 1'b0;
          end
        end
        S_RUN: begin
          if (accept && in_last) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (empty) state_q <= S_DONE;
        end
      endcase
    end
  end

  assign im_we        = we_q;
  assign im_addr      = addr_q;
  assign im_wdata     = wdata_q;
  assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign word_count   = cnt_q;
  assign err_illegal  = ill_q;
  assign err_overflow = ovf_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder; expectations follow the
// ENC_EXT_EN setting of the build.
module tb_mips_instr_encoder;
  import mips_enc_pkg::*;

`ifdef ENC_EXT_EN
  localparam logic EXT = 1'b1;
`else
  localparam logic EXT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [5:0]  in_id = '0;
  logic [4:0]  in_rs = '0;
  logic [4:0]  in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;

  logic        in_ready, im_we, busy, done;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic [10:0] word_count;
  logic        err_illegal, err_overflow;

  logic        s_in_ready, s_im_we, s_busy, s_done;
  logic [1:0]  s_im_addr;
  logic [31:0] s_im_wdata;
  logic [2:0]  s_word_count;
  logic        s_err_illegal, s_err_overflow;

  mips_instr_encoder dut (
    .clk(clk), .rstn(rstn), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_id(in_id), .in_last(in_last),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target),
    .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .busy(busy), .done(done),
    .word_count(word_count),
    .err_illegal(err_illegal),
    .err_overflow(err_overflow)
  );

  mips_instr_encoder #(.ADDR_W(2), .BASE(0)) dut_s (
    .clk(clk), .rstn(rstn), .start(start),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_id(in_id), .in_last(in_last),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target),
    .im_we(s_im_we), .im_addr(s_im_addr),
    .im_wdata(s_im_wdata), .busy(s_busy),
    .done(s_done), .word_count(s_word_count),
    .err_illegal(s_err_illegal),
    .err_overflow(s_err_overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int stalls = 0;
  int run = 0;
  int maxrun = 0;
  logic [9:0]  cap_a [$];
  logic [31:0] cap_d [$];
  logic [1:0]  s_cap_a [$];

  always @(negedge clk) begin
    if (im_we) begin
      cap_a.push_back(im_addr);
      cap_d.push_back(im_wdata);
      run++;
      if (run > maxrun) maxrun = run;
    end else begin
      run = 0;
    end
    if (s_im_we) s_cap_a.push_back(s_im_addr);
  end

  task automatic expect_eq(input string tag,
                           input logic [63:0] got,
                           input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic begin_session();
    @(negedge clk);
    cap_a.delete();
    cap_d.delete();
    s_cap_a.delete();
    maxrun = 0;
    stalls = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [5:0] id,
                      input logic [4:0] rs,
                      input logic [4:0] rt,
                      input logic [4:0] rd,
                      input logic [4:0] sh,
                      input logic [15:0] imm,
                      input logic [25:0] tgt,
                      input logic last);
    int n;
    @(negedge clk);
    in_id = id; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_imm = imm; in_target = tgt;
    in_last = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      stalls++;
      @(negedge clk);
      n++;
    end
    if (n >= 40) expect_eq("ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
  endtask

  task automatic finish_session(input string tag);
    int n;
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    expect_eq({tag, "_done"}, 64'(done), 64'd1);
    expect_eq({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  function automatic logic [63:0] cap_at(input int i);
    return (i < cap_d.size()) ? {22'd0, cap_a[i], cap_d[i]}
                              : 64'hDEAD_0000_DEAD;
  endfunction

  logic [31:0] exp4 [4];

  initial begin
    repeat (2) @(negedge clk);
    expect_eq("rst_ready", 64'(in_ready), 64'd0);
    expect_eq("rst_we", 64'(im_we), 64'd0);
    expect_eq("rst_busy", 64'(busy), 64'd0);
    expect_eq("rst_done", 64'(done), 64'd0);
    expect_eq("rst_addr", 64'(im_addr), 64'd0);
    expect_eq("rst_wdata", 64'(im_wdata), 64'd0);
    expect_eq("rst_wc", 64'(word_count), 64'd0);
    expect_eq("rst_errs", {err_illegal, err_overflow}, 64'd0);
    rstn = 1'b1;

    begin_session();
    expect_eq("s1_busy", 64'(busy), 64'd1);
    expect_eq("s1_ready", 64'(in_ready), 64'd1);
    send(ID_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'd0, 1'b0);
    send(ID_ADD, 5'd8, 5'd9, 5'd10, 5'd0, 16'd0, 26'd0, 1'b1);
    finish_session("s1");
    expect_eq("s1_n", cap_d.size(), 64'd2);
    expect_eq("s1_w0", cap_at(0), {22'd0, 10'd0, 32'h20080005});
    expect_eq("s1_w1", cap_at(1), {22'd0, 10'd1, 32'h01095020});
    expect_eq("s1_wc", 64'(word_count), 64'd2);
    expect_eq("s1_ill", 64'(err_illegal), 64'd0);

    begin_session();
    send(ID_LW, 5'd29, 5'd9, 5'd0, 5'd0, 16'd4, 26'd0, 1'b0);
    send(ID_SW, 5'd29, 5'd8, 5'd0, 5'd0, 16'd8, 26'd0, 1'b0);
    send(ID_BEQ, 5'd8, 5'd9, 5'd0, 5'd0, 16'hFFFF, 26'd0, 1'b0);
    send(ID_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10, 1'b1);
    finish_session("s2");
    exp4[0] = 32'h8FA90004;
    exp4[1] = 32'hAFA80008;
    exp4[2] = 32'h1109FFFF;
    exp4[3] = 32'h08000010;
    expect_eq("s2_n", cap_d.size(), 64'd4);
    for (int i = 0; i < 4; i++)
      expect_eq($sformatf("s2_w%0d", i), cap_at(i),
                {22'd0, 10'(i), exp4[i]});
    expect_eq("s2_wc", 64'(word_count), 64'd4);

    begin_session();
    send(ID_SLL, 5'd31, 5'd9, 5'd8, 5'd2, 16'd0, 26'd0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    expect_eq("s3_lat_k", 64'(im_we), 64'd0);
    @(negedge clk);
    expect_eq("s3_lat_k1", 64'(im_we), 64'(EXT));
    finish_session("s3");
    expect_eq("s3_n", cap_d.size(), 64'(EXT));
    if (EXT) expect_eq("s3_w0", cap_at(0), {22'd0, 10'd0, 32'h00094080});
    expect_eq("s3_ill", 64'(err_illegal), 64'(!EXT));
    expect_eq("s3_wc", 64'(word_count), 64'(EXT));

    begin_session();
    send(6'd63, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b1);
    finish_session("s3b");
    expect_eq("s3b_n", cap_d.size(), 64'd0);
    expect_eq("s3b_ill", 64'(err_illegal), 64'd1);

    begin_session();
    expect_eq("s4_ill_clr", 64'(err_illegal), 64'd0);
    for (int i = 0; i < 8; i++)
      send(ID_ORI, 5'd0, 5'(i), 5'd0, 5'd0, 16'(i), 26'd0, i == 7);
    finish_session("s4");
    expect_eq("s4_n", cap_d.size(), 64'd8);
    expect_eq("s4_run", maxrun, 64'd8);
    expect_eq("s4_stalls", stalls, 64'd0);
    for (int i = 0; i < 8; i++)
      expect_eq($sformatf("s4_w%0d", i), cap_at(i),
                {22'd0, 10'(i), 32'h34000000 | (i << 16) | i});

    begin_session();
    for (int i = 0; i < 6; i++)
      send(ID_ADDI, 5'd0, 5'd1, 5'd0, 5'd0, 16'(i), 26'd0, i == 5);
    finish_session("s5");
    expect_eq("s5_big_n", cap_d.size(), 64'd6);
    expect_eq("s5_big_ovf", 64'(err_overflow), 64'd0);
    expect_eq("s5_n", s_cap_a.size(), 64'd4);
    for (int i = 0; i < 4; i++)
      expect_eq($sformatf("s5_a%0d", i),
                (i < s_cap_a.size()) ? 64'(s_cap_a[i]) : 64'hDEAD,
                64'(i));
    expect_eq("s5_ovf", 64'(s_err_overflow), 64'd1);
    expect_eq("s5_wc", 64'(s_word_count), 64'd4);
    expect_eq("s5_done", 64'(s_done), 64'd1);

    begin_session();
    send(ID_ADDI, 5'd0, 5'd2, 5'd0, 5'd0, 16'd7, 26'd0, 1'b0);
    send(ID_ADDI, 5'd0, 5'd3, 5'd0, 5'd0, 16'd8, 26'd0, 1'b0);
    send(ID_ADDI, 5'd0, 5'd4, 5'd0, 5'd0, 16'd9, 26'd0, 1'b0);
    #2;
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    expect_eq("s6_we", 64'(im_we), 64'd0);
    expect_eq("s6_addr", 64'(im_addr), 64'd0);
    expect_eq("s6_wdata", 64'(im_wdata), 64'd0);
    expect_eq("s6_wc", 64'(word_count), 64'd0);
    expect_eq("s6_flags", {in_ready, busy, done}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    begin_session();
    send(ID_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'd0, 1'b1);
    finish_session("s6b");
    expect_eq("s6b_n", cap_d.size(), 64'd1);
    expect_eq("s6b_w0", cap_at(0), {22'd0, 10'd0, 32'h20080005});
    expect_eq("s6b_wc", 64'(word_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
